// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: port 0 has fixed top priority, ports 1..NPORTS-1 rotate round-robin.
// Each grant tenure is bounded to MAXBEAT acknowledged beats and followed by a one-cycle RELEASE.
module mem_port_arbiter #(
   parameter int NPORTS  = 4,
   parameter int MAXBEAT = 8,
   parameter int IDW     = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NPORTS-1:0] req_i,
   input  logic [NPORTS-1:0] last_i,
   input  logic              mem_ack_i,
   output logic [NPORTS-1:0] gnt_o,
   output logic [IDW-1:0]    gnt_id_o,
   output logic              mem_cyc_o,
   output logic              busy_o
);

   localparam int BW = $clog2(MAXBEAT) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBEAT - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]        r_state;
   logic [IDW-1:0]    r_rr_ptr;
   logic [BW-1:0]     r_beat;
   logic [NPORTS-1:0] r_gnt;
   logic [IDW-1:0]    r_gnt_id;
   logic              r_cyc;
   logic              r_busy;

   logic              w_win_vld;
   logic [IDW-1:0]    w_win_id;
   logic              w_req_g;
   logic              w_last_g;
   logic              w_end;
   int                w_k;

   // Port 0 wins outright; otherwise scan 1..NPORTS-1 starting at rr_ptr and wrapping back to 1.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_id  = '0;
      w_k       = 0;
      if (req_i[0]) begin
         w_win_vld = 1'b1;
      end else begin
         for (int i = 0; i < NPORTS - 1; i++) begin
            w_k = int'(r_rr_ptr) + i;
            if (w_k >= NPORTS) w_k = w_k - (NPORTS - 1);
            if (!w_win_vld && req_i[w_k]) begin
               w_win_vld = 1'b1;
               w_win_id  = IDW'(w_k);
            end
         end
      end
   end

   always_comb begin
      w_req_g  = 1'b0;
      w_last_g = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         if (r_gnt_id == IDW'(i)) begin
            w_req_g  = req_i[i];
            w_last_g = last_i[i];
         end
      end
   end

   // Any one of these closes the tenure; preemption by port 0 only lands on a beat boundary.
   assign w_end = (mem_ack_i && w_last_g)
               || (mem_ack_i && (r_beat == LAST_BEAT))
               || (mem_ack_i && req_i[0] && (r_gnt_id != '0))
               || !w_req_g;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= IDW'(1);
         r_beat   <= '0;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_cyc    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_state  <= S_GRANT;
                  r_beat   <= '0;
                  r_gnt    <= NPORTS'(1) << w_win_id;
                  r_gnt_id <= w_win_id;
                  r_cyc    <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            S_GRANT: begin
               if (mem_ack_i) r_beat <= r_beat + 1'b1;
               if (w_end) begin
                  r_state <= S_RELEASE;
                  r_gnt   <= '0;
                  r_cyc   <= 1'b0;
               end
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (r_gnt_id != '0) begin
                  if (r_gnt_id == IDW'(NPORTS - 1)) r_rr_ptr <= IDW'(1);
                  else                              r_rr_ptr <= r_gnt_id + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_cyc   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o     = r_gnt;
   assign gnt_id_o  = r_gnt_id;
   assign mem_cyc_o = r_cyc;
   assign busy_o    = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues the expected grant id, beat count and
// dead-time gap of each tenure; a negedge monitor checks grants as they appear and end.
module tb_mem_port_arbiter;

   localparam int NPORTS = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [NPORTS-1:0] req_i;
   logic [NPORTS-1:0] last_i;
   logic              mem_ack_i;
   logic [NPORTS-1:0] gnt_o;
   logic [1:0]        gnt_id_o;
   logic              mem_cyc_o;
   logic              busy_o;

   mem_port_arbiter #(.NPORTS(NPORTS), .MAXBEAT(8), .IDW(2)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .last_i    (last_i),
      .mem_ack_i (mem_ack_i),
      .gnt_o     (gnt_o),
      .gnt_id_o  (gnt_id_o),
      .mem_cyc_o (mem_cyc_o),
      .busy_o    (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int id;
      int nacks;
      int gap;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_err = 0;
   int   acks  = 0;
   int   zc    = 0;
   logic [NPORTS-1:0] prev_gnt = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int id, input int nacks, input int gap);
      exp_t e;
      e.id = id; e.nacks = nacks; e.gap = gap;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: grant start pops the scoreboard, grant end checks the beat count.
   always @(negedge clk_i) begin
      chk("onehot", int'($countones(gnt_o) <= 1), 1);
      chk("cyc_eq_gnt", int'(mem_cyc_o), int'(|gnt_o));
      if (gnt_o != '0 && prev_gnt == '0) begin
         if (q.size() == 0) begin
            chk("unexpected_grant", int'(gnt_o), 0);
         end else begin
            cur = q.pop_front();
            chk("grant_id", int'(gnt_id_o), cur.id);
            chk("grant_vec", int'(gnt_o), 1 << cur.id);
            if (cur.gap >= 0) chk("dead_gap", zc, cur.gap);
         end
         acks = 0;
      end
      if (gnt_o != '0 && mem_ack_i && !rst_i) acks++;
      if (gnt_o == '0 && prev_gnt != '0) chk("tenure_beats", acks, cur.nacks);
      if (gnt_o == '0) zc = (prev_gnt != '0) ? 1 : zc + 1;
      prev_gnt = gnt_o;
   end

   initial begin
      rst_i = 1'b1; req_i = '0; last_i = '0; mem_ack_i = 1'b0;
      tick(); tick();
      chk("rst_gnt", int'(gnt_o), 0);
      chk("rst_id", int'(gnt_id_o), 0);
      chk("rst_cyc", int'(mem_cyc_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      rst_i = 1'b0;
      tick();

      // Single port 2 tenure ended by last_i on the third ack.
      push(2, 3, -1);
      req_i = 4'b0100;
      tick();
      chk("t1_gnt", int'(gnt_o), 4);
      chk("t1_busy", int'(busy_o), 1);
      mem_ack_i = 1'b1;
      tick(); tick();
      last_i = 4'b0100;
      tick();
      req_i = '0; mem_ack_i = 1'b0; last_i = '0;
      chk("t1_release_gnt", int'(gnt_o), 0);
      chk("t1_release_busy", int'(busy_o), 1);
      chk("t1_release_id", int'(gnt_id_o), 2);
      tick();
      chk("t1_idle_busy", int'(busy_o), 0);

      // Round-robin with MAXBEAT cut-off; rr_ptr=3 after port 2, so order is 3,1,2,3.
      push(3, 8, -1); push(1, 8, 2); push(2, 8, 2); push(3, 8, 2);
      req_i = 4'b1110; mem_ack_i = 1'b1;
      tick();
      repeat (38) tick();
      req_i = '0; mem_ack_i = 1'b0;
      chk("t2_release_gnt", int'(gnt_o), 0);
      tick();

      // Preemption of port 1 by port 0 on the third ack, then port 2 via rr_ptr=2.
      push(1, 3, -1);
      req_i = 4'b0110;
      tick();
      mem_ack_i = 1'b1;
      tick(); tick();
      req_i = 4'b0111;
      tick();
      chk("t3_preempt_gnt", int'(gnt_o), 0);
      req_i = 4'b0101; mem_ack_i = 1'b0;
      push(0, 2, 2);
      tick(); tick();
      chk("t3_p0_gnt", int'(gnt_o), 1);
      mem_ack_i = 1'b1;
      tick();
      last_i = 4'b0001;
      tick();
      req_i = 4'b1110; mem_ack_i = 1'b0; last_i = '0;
      push(2, 1, 2);
      tick(); tick();
      mem_ack_i = 1'b1; last_i = 4'b0100;
      tick();

      // Port 3 abandons its tenure without any ack.
      req_i = 4'b1000; mem_ack_i = 1'b0; last_i = '0;
      push(3, 0, 2);
      tick(); tick();
      chk("t4_p3_cyc", int'(mem_cyc_o), 1);
      req_i = '0;
      tick();
      chk("t4_abandon_cyc", int'(mem_cyc_o), 0);
      tick();

      // rr_ptr wrapped to 1: port 1 beats port 3.
      push(1, 1, -1);
      req_i = 4'b1010;
      tick();
      mem_ack_i = 1'b1; last_i = 4'b0010;
      tick();
      req_i = 4'b0100; mem_ack_i = 1'b0; last_i = '0;
      push(2, 5, 2);
      tick(); tick();
      mem_ack_i = 1'b1;
      repeat (5) tick();
      mem_ack_i = 1'b0; rst_i = 1'b1;
      tick();
      chk("t5_rst_gnt", int'(gnt_o), 0);
      chk("t5_rst_cyc", int'(mem_cyc_o), 0);
      chk("t5_rst_busy", int'(busy_o), 0);
      chk("t5_rst_id", int'(gnt_id_o), 0);
      rst_i = 1'b0; req_i = 4'b0110;
      push(1, 1, -1);
      tick();
      chk("t5_after_rst_id", int'(gnt_id_o), 1);
      mem_ack_i = 1'b1; last_i = 4'b0010;
      tick();
      req_i = 4'b0100; mem_ack_i = 1'b0; last_i = '0;
      push(2, 1, 2);
      tick(); tick();
      mem_ack_i = 1'b1; last_i = 4'b0100;
      tick();
      req_i = '0; mem_ack_i = 1'b0; last_i = '0;
      tick();

      // Spurious ack/last while idle must not start anything.
      mem_ack_i = 1'b1; last_i = 4'b1111;
      repeat (3) begin
         tick();
         chk("t6_idle_gnt", int'(gnt_o), 0);
         chk("t6_idle_busy", int'(busy_o), 0);
      end
      mem_ack_i = 1'b0; last_i = '0;
      tick(); tick();
      chk("sb_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
